// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_responder slice.
// LFSR constants are only consumed when MEM_LATENCY_JITTER_EN is defined.
package mem_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_e;

   localparam int LFSR_W = 4;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b1001;
   localparam int MAX_LATENCY = 15;
   localparam int JITTER_MAX = 3;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
      return {l[2:0], l[3] ^ l[2]};
   endfunction

endpackage

// File: rtl/mem_lfsr.sv
// 4-bit latency-jitter LFSR; advances once per accepted request.
// Instantiated by mem_responder only when MEM_LATENCY_JITTER_EN is defined.
module mem_lfsr
   import mem_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_adv,
   output logic [LFSR_W-1:0] o_lfsr
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;

   always_comb begin
      lfsr_d = lfsr_q;
      if (i_adv) begin
         lfsr_d = lfsr_next(lfsr_q);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign o_lfsr = lfsr_q;

endmodule

// File: rtl/mem_responder.sv
// Word-granular backing memory with fixed (or LFSR-jittered) response latency.
// Optional feature: define MEM_LATENCY_JITTER_EN to add 0..3 cycles of latency per request.
module mem_responder
   import mem_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int ADDR_W  = 12
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic        o_mem_ready,
   input  logic [31:0] i_mem_addr,
   input  logic        i_mem_ren,
   input  logic        i_mem_wen,
   input  logic [31:0] i_mem_wdata,
   output logic [31:0] o_mem_rdata,
   output logic        o_mem_valid
);

`ifdef MEM_LATENCY_JITTER_EN
   localparam int LAT_MAX = MAX_LATENCY + JITTER_MAX;
`else
   localparam int LAT_MAX = MAX_LATENCY;
`endif
   localparam int CNT_W = $clog2(LAT_MAX + 1);

   mem_state_e        state_q;
   mem_state_e        state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic [CNT_W-1:0]  lat;
   logic              rd_pend_q;
   logic              rd_pend_d;
   logic              valid_q;
   logic              valid_d;
   logic [31:0]       rdata_q;
   logic [31:0]       rdata_d;
   logic [31:0]       mem_q [0:(1<<ADDR_W)-1];
   logic [ADDR_W-1:0] idx;
   logic              accept;
   logic              wr_acc;
   logic              rd_acc;
   logic              unused_addr_bits;

   // Upper and byte-offset address bits are deliberately dropped, so addresses alias.
   assign idx              = i_mem_addr[ADDR_W+1:2];
   assign unused_addr_bits = &{1'b0, i_mem_addr[31:ADDR_W+2], i_mem_addr[1:0]};

   assign accept = (state_q == IDLE) & (i_mem_ren | i_mem_wen);
   assign wr_acc = accept & i_mem_wen;
   assign rd_acc = accept & i_mem_ren & ~i_mem_wen;

`ifdef MEM_LATENCY_JITTER_EN
   logic [LFSR_W-1:0] lfsr;
   logic              unused_lfsr_hi;

   mem_lfsr u_lfsr (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_adv   (accept),
      .o_lfsr  (lfsr)
   );

   // Extra latency uses the LFSR value before this accept advances it.
   assign lat            = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
   assign unused_lfsr_hi = &{1'b0, lfsr[LFSR_W-1:2]};
`else
   assign lat = CNT_W'(LATENCY);
`endif

   always_ff @(posedge i_clk) begin
      if (wr_acc) begin
         mem_q[idx] <= i_mem_wdata;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         rd_pend_q <= 1'b0;
         valid_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rd_pend_q <= rd_pend_d;
         valid_q   <= valid_d;
         rdata_q   <= rdata_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rd_pend_d = rd_pend_q;
      rdata_d   = rdata_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = WAIT;
               cnt_d     = lat - CNT_W'(1);
               rd_pend_d = rd_acc;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (rd_acc) begin
         rdata_d = mem_q[idx];
      end
   end

   // Valid is registered on the edge that returns the FSM to IDLE.
   always_comb begin
      o_mem_ready = (state_q == IDLE);
      valid_d     = (state_q == WAIT) && (cnt_q == '0) && rd_pend_q;
   end

   assign o_mem_rdata = rdata_q;
   assign o_mem_valid = valid_q;

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: request table plus reset/busy corner sequences,
// read data checked through a due-cycle scoreboard.
module tb_mem_responder;

   localparam int LAT = 4;
   localparam int AW  = 10;

   typedef struct {
      logic        ren;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } sb_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        o_mem_ready;
   logic [31:0] i_mem_addr = '0;
   logic        i_mem_ren = 1'b0;
   logic        i_mem_wen = 1'b0;
   logic [31:0] i_mem_wdata = '0;
   logic [31:0] o_mem_rdata;
   logic        o_mem_valid;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   sb_t  sb[$];
   vec_t vecs[16];
   logic [3:0] lf_m = 4'b1001;

   mem_responder #(.LATENCY(LAT), .ADDR_W(AW)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .o_mem_ready (o_mem_ready),
      .i_mem_addr  (i_mem_addr),
      .i_mem_ren   (i_mem_ren),
      .i_mem_wen   (i_mem_wen),
      .i_mem_wdata (i_mem_wdata),
      .o_mem_rdata (o_mem_rdata),
      .o_mem_valid (o_mem_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic take_lat(output int l);
`ifdef MEM_LATENCY_JITTER_EN
      l    = LAT + int'(lf_m[1:0]);
      lf_m = {lf_m[2:0], lf_m[3] ^ lf_m[2]};
`else
      l = LAT;
`endif
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!o_mem_ready && n < 50) begin
         step();
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout at cycle %0d: got ready=0 expected ready=1", cyc);
      end
   endtask

   // Present a request, expect a read to land on the scoreboard, and check busy window.
   task automatic run_req(input vec_t v);
      int l;
      int e0;
      wait_ready();
      i_mem_ren   = v.ren;
      i_mem_wen   = v.wen;
      i_mem_addr  = v.addr;
      i_mem_wdata = v.wdata;
      step();
      e0          = cyc;
      i_mem_ren   = 1'b0;
      i_mem_wen   = 1'b0;
      i_mem_addr  = $urandom;
      i_mem_wdata = $urandom;
      take_lat(l);
      if (v.ren && !v.wen) sb.push_back('{v.exp, e0 + l});
      for (int k = 0; k < l; k++) begin
         chk({v.name, "_busy"}, {31'b0, o_mem_ready}, 32'd0);
         step();
      end
      chk({v.name, "_ready_again"}, {31'b0, o_mem_ready}, 32'd1);
   endtask

   task automatic assert_reset();
      rst_n = 1'b0;
      sb.delete();
      lf_m  = 4'b1001;
   endtask

   // Scoreboard monitor, sampled 2 time units after each rising edge.
   always begin
      sb_t e;
      @(posedge clk);
      #2;
      if (!rst_n) begin
         if (o_mem_valid) begin
            checks++;
            errors++;
            $display("FAIL valid_in_reset at cycle %0d: got valid=1 expected valid=0", cyc);
         end
      end else if (o_mem_valid) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid at cycle %0d: got valid=1 rdata=%h expected no pulse", cyc, o_mem_rdata);
         end else begin
            e = sb.pop_front();
            if (o_mem_rdata !== e.data || cyc != e.due) begin
               errors++;
               $display("FAIL read_resp at cycle %0d: got rdata=%h expected rdata=%h at cycle %0d", cyc, o_mem_rdata, e.data, e.due);
            end
         end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
         checks++;
         errors++;
         $display("FAIL missing_valid at cycle %0d: got valid=0 expected rdata=%h", cyc, sb[0].data);
         e = sb.pop_front();
      end
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         "wr_100"};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, "rd_100"};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h11,        32'h0,         "wr_200"};
      vecs[3]  = '{1'b0, 1'b1, 32'h0000_0204, 32'h22,        32'h0,         "wr_204"};
      vecs[4]  = '{1'b0, 1'b1, 32'h0000_0208, 32'h33,        32'h0,         "wr_208"};
      vecs[5]  = '{1'b0, 1'b1, 32'h0000_020C, 32'h44,        32'h0,         "wr_20c"};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         32'h11,        "fill_200"};
      vecs[7]  = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         32'h22,        "fill_204"};
      vecs[8]  = '{1'b1, 1'b0, 32'h0000_0208, 32'h0,         32'h33,        "fill_208"};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_020C, 32'h0,         32'h44,        "fill_20c"};
      vecs[10] = '{1'b0, 1'b1, 32'h0000_1003, 32'hCAFE_F00D, 32'h0,         "wr_alias"};
      vecs[11] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, "rd_alias"};
      vecs[12] = '{1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 32'h0,         "rw_300"};
      vecs[13] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,         32'h1234_5678, "rd_300"};
      vecs[14] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0BAD_F00D, 32'h0,         "wr_100b"};
      vecs[15] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         32'h0BAD_F00D, "rd_100b"};

      // Reset held with no requests, then released and observed.
      assert_reset();
      repeat (3) step();
      chk("rst_ready", {31'b0, o_mem_ready}, 32'd1);
      chk("rst_valid", {31'b0, o_mem_valid}, 32'd0);
      rst_n = 1'b1;
      chk("rst_rdata", o_mem_rdata, 32'h0);
      for (int k = 0; k < 20; k++) begin
         step();
         chk("post_rst_ready", {31'b0, o_mem_ready}, 32'd1);
         chk("post_rst_valid", {31'b0, o_mem_valid}, 32'd0);
      end

      for (int i = 0; i < 16; i++) begin
         run_req(vecs[i]);
      end

      // Request presented while busy is ignored, not queued.
      wait_ready();
      i_mem_ren  = 1'b1;
      i_mem_addr = 32'h0000_0100;
      step();
      begin
         int l;
         int e0;
         e0 = cyc;
         take_lat(l);
         sb.push_back('{32'h0BAD_F00D, e0 + l});
      end
      i_mem_ren   = 1'b0;
      i_mem_wen   = 1'b1;
      i_mem_wdata = 32'hFFFF_FFFF;
      step();
      step();
      i_mem_wen = 1'b0;
      wait_ready();
      run_req('{1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, "rd_after_busy"});

      // Reset in the middle of a read: no pulse, ready at once, rdata cleared.
      wait_ready();
      i_mem_ren  = 1'b1;
      i_mem_addr = 32'h0000_0200;
      step();
      i_mem_ren = 1'b0;
      sb.push_back('{32'h11, cyc + LAT});
      step();
      step();
      assert_reset();
      #1;
      chk("midrst_ready", {31'b0, o_mem_ready}, 32'd1);
      chk("midrst_valid", {31'b0, o_mem_valid}, 32'd0);
      chk("midrst_rdata", o_mem_rdata, 32'h0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("after_midrst_valid", {31'b0, o_mem_valid}, 32'd0);
      end
      run_req('{1'b1, 1'b0, 32'h0000_0204, 32'h0, 32'h22, "rd_after_rst"});

`ifdef MEM_LATENCY_JITTER_EN
      // Fresh LFSR after reset: ready-low windows of 5, 7, 6, 5 cycles.
      begin
         int exp_l[4] = '{5, 7, 6, 5};
         assert_reset();
         step();
         rst_n = 1'b1;
         step();
         for (int i = 0; i < 4; i++) begin
            int n;
            int l;
            i_mem_ren  = 1'b1;
            i_mem_addr = 32'h0000_0208;
            step();
            i_mem_ren = 1'b0;
            take_lat(l);
            sb.push_back('{32'h33, cyc + l});
            n = 0;
            while (!o_mem_ready && n < 40) begin
               step();
               n++;
            end
            chk("jitter_lat", n, exp_l[i]);
         end
      end
`endif

      repeat (LAT + 6) step();
      chk("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
